pool2_reader: RTL and testbench

- Reads the 16 conv2 output feature maps (f4 buffers, 8x8 each, 16-bit signed, written by the conv2 execution stage) and performs 2x2/stride-2 max pooling on all 16 channels in parallel.
- Streams the 16 pooled 4x4 maps (s4 layer) to the next stage, one window (16 channels) per valid/ready handshake.
- Acts as the reading end of the f4 buffer interface.

---
 rtl/pool2_reader_pkg.sv | 10 +
 rtl/pool2_reader_if.sv | 15 +
 rtl/pool2_reader_max_cmp.sv | 15 +
 rtl/pool2_reader.sv | 74 +++++++
 tb/tb_pool2_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pool2_reader_pkg.sv
// pool2_reader_pkg: shared constants, FSM encoding and bus slicing helper for pool2_reader.
package pool2_reader_pkg;
  localparam int DATA_W = 16;
  localparam int CH     = 16;
  localparam int FM_W   = 8;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_OUT, S_FIN} state_t;
  function automatic logic [DATA_W-1:0] ch_slice(input logic [CH*DATA_W-1:0] bus, input int k);
    return bus[k*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/pool2_reader_if.sv
// pool2_reader_if: control, f4 buffer read port and s4 stream of pool2_reader.
interface pool2_reader_if;
  import pool2_reader_pkg::*;
  logic                 start, busy, done;
  logic                 f4_rden;
  logic [5:0]           f4_raddr;
  logic [CH*DATA_W-1:0] f4_rdata;
  logic                 s4_valid, s4_ready;
  logic [3:0]           s4_addr;
  logic [CH*DATA_W-1:0] s4_data;
  modport master (input start, f4_rdata, s4_ready,
                  output busy, done, f4_rden, f4_raddr, s4_valid, s4_addr, s4_data);
  modport slave  (output start, f4_rdata, s4_ready,
                  input busy, done, f4_rden, f4_raddr, s4_valid, s4_addr, s4_data);
endinterface

// File: rtl/pool2_reader_max_cmp.sv
// max_cmp: registered signed running maximum for one channel.
module max_cmp import pool2_reader_pkg::*; (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_upd,
  input  logic signed [DATA_W-1:0] i_din,
  output logic signed [DATA_W-1:0] o_max
);
  logic signed [DATA_W-1:0] r_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_max <= '0;
    else if (i_load || (i_upd && i_din > r_max)) r_max <= i_din;
  assign o_max = r_max;
endmodule

// File: rtl/pool2_reader.sv
// pool2_reader: 2x2/stride-2 max pooling over 16 f4 maps, streamed as s4 windows.
// Build option POOL2_RELU_EN clamps negative pooled values to zero.
module pool2_reader import pool2_reader_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pool2_reader_if.master bus
);
  state_t               r_state, w_next;
  logic [3:0]           r_cnt, r_win;
  logic [5:0]           r_last_addr, w_addr;
  logic [RD_LAT-1:0]    r_vld_d, r_first_d;
  logic                 w_rden, w_hs, w_load, w_upd;
  logic [CH*DATA_W-1:0] w_max, w_data;
  // address bits: {orow, row lsb, ocol, col lsb} for an 8-wide map
  assign w_addr = {r_win[3:2], r_cnt[1], r_win[1:0], r_cnt[0]};
  assign w_hs   = bus.s4_valid & bus.s4_ready;
  assign w_load = r_vld_d[RD_LAT-1] & r_first_d[RD_LAT-1];
  assign w_upd  = r_vld_d[RD_LAT-1] & ~r_first_d[RD_LAT-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_READ : S_IDLE;
      S_READ:  w_next = (r_cnt == 4'd3) ? S_WAIT : S_READ;
      S_WAIT:  w_next = (r_cnt == 4'(RD_LAT-1)) ? S_OUT : S_WAIT;
      S_OUT:   w_next = !bus.s4_ready ? S_OUT : (r_win == 4'd15) ? S_FIN : S_READ;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_rden       = r_state == S_READ;
    bus.f4_rden  = w_rden;
    bus.f4_raddr = w_rden ? w_addr : r_last_addr;
    bus.busy     = r_state inside {S_READ, S_WAIT, S_OUT};
    bus.done     = r_state == S_FIN;
    bus.s4_valid = r_state == S_OUT;
    bus.s4_addr  = r_win;
    bus.s4_data  = w_data;
  end
  // r_cnt restarts on every state change: read index in READ, latency count in WAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt       <= '0;
      r_win       <= '0;
      r_last_addr <= '0;
      r_vld_d     <= '0;
      r_first_d   <= '0;
    end else begin
      r_cnt       <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
      r_win       <= w_hs ? r_win + 4'd1 : r_win;
      r_last_addr <= bus.f4_raddr;
      r_vld_d     <= RD_LAT'({r_vld_d, w_rden});
      r_first_d   <= RD_LAT'({r_first_d, w_rden && r_cnt == 4'd0});
    end
  for (genvar k = 0; k < CH; k++) begin : g_ch
    max_cmp u_max (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_upd  (w_upd),
      .i_din  (ch_slice(bus.f4_rdata, k)),
      .o_max  (w_max[k*DATA_W +: DATA_W])
    );
`ifdef POOL2_RELU_EN
    assign w_data[k*DATA_W +: DATA_W] = w_max[(k+1)*DATA_W-1] ? '0 : w_max[k*DATA_W +: DATA_W];
`else
    assign w_data[k*DATA_W +: DATA_W] = w_max[k*DATA_W +: DATA_W];
`endif
  end
endmodule

// File: tb/tb_pool2_reader.sv
// tb_pool2_reader: scoreboard + table-driven bench for pool2_reader (RD_LAT 1 and 2 instances).
module tb_pool2_reader;
  import pool2_reader_pkg::*;
  typedef struct { logic [3:0] addr; logic [CH*DATA_W-1:0] data; } exp_t;
  typedef struct { logic [15:0] a, b, c, d, raw, relu; } vec_t;
  logic clk = 0, rst_n;
  int   cyc = 0, tests = 0, fails = 0, done_cnt = 0, last_hs = -10;
  logic [DATA_W-1:0]    mem [CH][64];
  logic [CH*DATA_W-1:0] rd_q, rd2_a, rd2_b;
  logic [CH*DATA_W-1:0] win_log [16];
  exp_t sb [$];
  vec_t tbl [5];
  pool2_reader_if bus ();
  pool2_reader_if bus2 ();
  pool2_reader #(.RD_LAT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  pool2_reader #(.RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [CH*DATA_W-1:0] rd_word(input logic [5:0] a);
    logic [CH*DATA_W-1:0] r;
    for (int k = 0; k < CH; k++) r[k*DATA_W +: DATA_W] = mem[k][a];
    return r;
  endfunction
  always @(posedge clk) begin
    if (bus.f4_rden) rd_q <= rd_word(bus.f4_raddr);
    if (bus2.f4_rden) rd2_a <= rd_word(bus2.f4_raddr);
    rd2_b <= rd2_a;
  end
  assign bus.f4_rdata  = rd_q;
  assign bus2.f4_rdata = rd2_b;
  function automatic logic [CH*DATA_W-1:0] model(input int w);
    logic [CH*DATA_W-1:0] r;
    logic signed [DATA_W-1:0] m, v;
    int base;
    base = (w / 4) * 16 + (w % 4) * 2;
    for (int k = 0; k < CH; k++) begin
      m = mem[k][base];
      for (int i = 1; i < 4; i++) begin
        v = mem[k][base + (i / 2) * FM_W + (i % 2)];
        if (v > m) m = v;
      end
`ifdef POOL2_RELU_EN
      if (m < 0) m = '0;
`endif
      r[k*DATA_W +: DATA_W] = m;
    end
    return r;
  endfunction
  task automatic chk(input string name, input logic [CH*DATA_W-1:0] act, input logic [CH*DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.s4_valid && bus.s4_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_window", 1'b1, 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("s4_addr", bus.s4_addr, e.addr);
        chk("s4_data", bus.s4_data, e.data);
      end
      win_log[bus.s4_addr] = bus.s4_data;
      last_hs = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_after_last_hs", cyc, last_hs + 1);
    end
  end
  task automatic push_pass();
    for (int w = 0; w < 16; w++) sb.push_back('{addr: 4'(w), data: model(w)});
  endtask
  task automatic start_pass();
    push_pass();
    @(posedge clk); #1 bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
  endtask
  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 400) begin @(posedge clk); #1; n++; end
    chk("done_once", done_cnt, base + 1);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int t0, base, n;
    logic [5:0] exp_a [4];
    logic [DATA_W-1:0] d_ch3;
    logic [CH*DATA_W-1:0] held;
    exp_a = '{6'd0, 6'd1, 6'd8, 6'd9};
    tbl[0] = '{16'hFF80, 16'h0005, 16'hFFFF, 16'h8000, 16'h0005, 16'h0005};
    tbl[1] = '{16'hFFF0, 16'hFFF8, 16'h8000, 16'hFFF1, 16'hFFF8, 16'h0000};
    tbl[2] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 16'h0004};
    tbl[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
    for (int k = 0; k < CH; k++) for (int a = 0; a < 64; a++) mem[k][a] = 16'(k * 64 + a);
    rst_n = 0; bus.start = 0; bus.s4_ready = 1; bus2.start = 0; bus2.s4_ready = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rden", bus.f4_rden, 0);
    chk("rst_raddr", bus.f4_raddr, 0);
    chk("rst_valid", bus.s4_valid, 0);
    chk("rst_s4_addr", bus.s4_addr, 0);
    chk("rst_s4_data", bus.s4_data, 0);
    rst_n = 1;
    // ramp pass with read timing; RD_LAT=2 instance started alongside
    push_pass();
    @(posedge clk); #1 bus.start = 1; bus2.start = 1; t0 = cyc;
    @(posedge clk); #1 bus.start = 0; bus2.start = 0;
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rden_cycle", bus.f4_rden, 1);
      chk("raddr_order", bus.f4_raddr, exp_a[i]);
      @(posedge clk); #1;
    end
    chk("rden_off_in_wait", bus.f4_rden, 0);
    chk("raddr_hold", bus.f4_raddr, 9);
    chk("valid_not_yet", bus.s4_valid, 0);
    @(posedge clk); #1;
    chk("valid_lat1_cycle", cyc - t0, 6);
    chk("valid_lat1", bus.s4_valid, 1);
    chk("valid_lat2_early", bus2.s4_valid, 0);
    @(posedge clk); #1;
    chk("valid_lat2", bus2.s4_valid, 1);
    wait_done(0);
    chk("ramp_w0_ch0", win_log[0][15:0], 9);
    chk("ramp_w15_ch0", win_log[15][15:0], 63);
    chk("ramp_w15_ch15", win_log[15][CH*DATA_W-1 -: DATA_W], 1023);
    // signed compare table on window 0, channel 3
    for (int v = 0; v < 5; v++) begin
      mem[3][0] = tbl[v].a; mem[3][1] = tbl[v].b; mem[3][8] = tbl[v].c; mem[3][9] = tbl[v].d;
`ifdef POOL2_RELU_EN
      d_ch3 = tbl[v].relu;
`else
      d_ch3 = tbl[v].raw;
`endif
      base = done_cnt;
      start_pass();
      wait_done(base);
      chk($sformatf("signed_ch3_v%0d", v), win_log[0][3*DATA_W +: DATA_W], d_ch3);
    end
    // back-pressure on window 2
    base = done_cnt;
    start_pass();
    n = 0;
    while (!(bus.s4_valid && bus.s4_addr == 4'd2) && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp_reached_w2", bus.s4_valid && bus.s4_addr == 4'd2, 1);
    bus.s4_ready = 0;
    held = bus.s4_data;
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", bus.s4_valid, 1);
      chk("bp_addr", bus.s4_addr, 2);
      chk("bp_data", bus.s4_data, held);
      chk("bp_no_rden", bus.f4_rden, 0);
      if (i < 6) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 bus.s4_ready = 1;
    chk("bp_valid_8th", bus.s4_valid, 1);
    @(posedge clk); #1;
    chk("bp_resume_rden", bus.f4_rden, 1);
    chk("bp_resume_addr", bus.f4_raddr, 6);
    wait_done(base);
    // asynchronous reset during window 5
    start_pass();
    n = 0;
    while (!(bus.s4_addr == 4'd5 && bus.f4_rden) && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst_reached_w5", bus.s4_addr, 5);
    base = done_cnt;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rden", bus.f4_rden, 0);
    chk("mid_rst_raddr", bus.f4_raddr, 0);
    chk("mid_rst_valid", bus.s4_valid, 0);
    chk("mid_rst_s4_addr", bus.s4_addr, 0);
    chk("mid_rst_s4_data", bus.s4_data, 0);
    sb.delete();
    repeat (5) @(posedge clk); #1;
    chk("mid_rst_no_done", done_cnt, base);
    rst_n = 1;
    start_pass();
    wait_done(base);
    // start pulses while busy and during FIN are ignored
    base = done_cnt;
    start_pass();
    repeat (10) @(posedge clk); #1 bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    n = 0;
    while (!bus.done && n < 400) begin @(posedge clk); #1; n++; end
    chk("fin_seen", bus.done, 1);
    bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    repeat (30) @(posedge clk); #1;
    chk("fin_start_ignored_busy", bus.busy, 0);
    chk("fin_start_one_done", done_cnt, base + 1);
    chk("fin_start_no_extra_windows", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
